mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 512x32 RAM between two requesters: the CPU memory path
//  (Control/MAR/MDR Read/Write) and a DMA/program-loader port.
//  Serialises transactions: one at a time, each with a one-cycle ram_rd/ram_wr strobe.
//  Acknowledges each transaction with a single-cycle pulse.
//  Arbitration: CPU has fixed priority, with a starvation bound for DMA.
//  Sits between the datapath memory interface and the RAM; cpu_stall holds Control in its wait state.
// PARAMETERS
//  AW        9   RAM address width
//  DW        32  data width
//  RD_LAT    1   RAM read latency in cycles (ram_rd strobe to ram_rdata valid); >=1
//  MAX_WAIT  4   number of consecutive lost conflicts after which DMA wins; 0 = DMA always wins conflicts
// PORTS
//  clk        in   1   system clock, rising edge
//  clr        in   1   reset, asynchronous, active-low (clr=0 resets)
//  cpu_req    in   1   CPU transaction request (level)
//  cpu_we     in   1   1=write, 0=read
//  cpu_addr   in   AW  CPU address (from MAR)
//  cpu_wdata  in   DW  CPU write data (from MDR)
//  cpu_ack    out  1   one-cycle completion pulse
//  cpu_rdata  out  DW  CPU read data; valid with cpu_ack, held until the next CPU read completes
//  cpu_stall  out  1   cpu_req & ~cpu_ack (combinational)
//  dma_req    in   1   DMA transaction request (level)
//  dma_we     in   1   1=write, 0=read
//  dma_addr   in   AW  DMA address
//  dma_wdata  in   DW  DMA write data
//  dma_ack    out  1   one-cycle completion pulse
//  dma_rdata  out  DW  DMA read data; same rules as cpu_rdata
//  ram_rd     out  1   RAM read strobe
//  ram_wr     out  1   RAM write strobe
//  ram_addr   out  AW  RAM address
//  ram_wdata  out  DW  RAM write data
//  ram_rdata  in   DW  RAM read data
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; starve_cnt=0; all outputs 0, incl. rdata regs.
//    Takes effect immediately (async): an in-flight transaction is aborted, no ack follows.
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//  IDLE: at each edge, if any req is high, select an owner and go to ISSUE.
//    Latch owner, we, addr and wdata at that edge.
//  Selection: only one req -> that requester.
//    Both -> CPU, unless starve_cnt==MAX_WAIT, then DMA.
//  starve_cnt: +1 (saturating at MAX_WAIT) on each conflict the CPU wins; cleared when DMA is granted.
//  ISSUE (1 cycle): ram_rd=~we or ram_wr=we; ram_addr and ram_wdata come from the latches.
//    Write -> DONE. Read -> WAIT.
//  WAIT (RD_LAT cycles): strobes low. At the final WAIT edge, ram_rdata is captured into the owner's rdata reg.
//  DONE (1 cycle): owner's ack=1 -> IDLE.
//  Latency from the sampling edge to ack: write = 2 cycles; read = 2+RD_LAT cycles.
//    Back-to-back turnaround: 1 IDLE cycle minimum.
//  Requester contract: hold req/we/addr/wdata until ack; drop req in the cycle after ack.
//    A req still high in IDLE is treated as a new transaction.
//  req dropped, or addr/data changed, after the grant: ignored. The latched transaction completes and ack still pulses.
//  Strobes: exactly one strobe per transaction; ram_rd and ram_wr never high together.
//  ram_addr/ram_wdata are 0 outside ISSUE.
//  Non-owner ack and rdata are unaffected by the other requester's transaction.
//  Address is full AW bits, no wrap logic; the arbiter passes addresses through unchanged.
// STRUCTURE
//  Package minisrc_mem_pkg: state encoding (IDLE/ISSUE/WAIT/DONE); owner encoding OWN_CPU=0, OWN_DMA=1;
//    defaults for AW and DW.
//  Sub-module mem_arb_select: conflict decision plus the starve_cnt register
//    (inputs: cpu_req, dma_req, grant_en; output: owner).
//  Top level holds the FSM, latches, RD_LAT wait counter and rdata regs.
// TESTING
//  1. RAM[5]=32'hDEADBEEF; CPU read addr 5 -> ram_rd high 1 cycle with ram_addr=5.
//     cpu_ack 3 cycles after the sampling edge (RD_LAT=1); cpu_rdata=32'hDEADBEEF.
//  2. DMA write addr 9'h1FF, data 32'h12345678 -> single ram_wr, dma_ack after 2 cycles.
//     A following CPU read of 9'h1FF returns 32'h12345678.
//  3. cpu_req and dma_req held high continuously, MAX_WAIT=4 -> grant order CPU,CPU,CPU,CPU,DMA, then repeating.
//     Never two strobes in one cycle.
//  4. clr=0 during WAIT of a CPU read -> all outputs 0 within the same cycle.
//     No cpu_ack after release; the next request completes normally.
//  5. CPU read addr 3; req dropped and addr changed to 7 one cycle after the grant -> ram_addr=3; cpu_ack pulses once.
//  6. RD_LAT=2 build, CPU read -> ack 4 cycles after the sampling edge; ram_rdata captured at the second WAIT edge.

Source files
------------

// File: rtl/minisrc_mem_pkg.sv
// Shared encodings and default widths for the RAM port arbiter.
package minisrc_mem_pkg;

    localparam int unsigned DEFAULT_AW = 9;
    localparam int unsigned DEFAULT_DW = 32;

    // Arbiter FSM state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Transaction owner encoding
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_select.sv
// Owner selection: CPU wins conflicts until DMA has lost MAX_WAIT in a row.
module mem_arb_select
    import minisrc_mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic grant_en,
    output logic owner
);

    localparam int unsigned CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] CntMax = CW'(MAX_WAIT);

    logic [CW-1:0] starve_q, starve_d;

    // Owner decision; with MAX_WAIT=0 the counter sits at its max so DMA always wins
    always_comb begin
        owner = OWN_CPU;
        if (dma_req && (!cpu_req || (starve_q == CntMax))) begin
            owner = OWN_DMA;
        end
    end

    // Count conflicts lost by DMA (saturating); any DMA grant clears the count
    always_comb begin
        starve_d = starve_q;
        if (grant_en) begin
            if (owner == OWN_DMA) begin
                starve_d = '0;
            end else if (dma_req && (starve_q != CntMax)) begin
                starve_d = starve_q + CW'(1);
            end
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and DMA accesses onto the single-port RAM, one at a time.
module mem_port_arbiter
    import minisrc_mem_pkg::*;
#(
    parameter int unsigned AW       = DEFAULT_AW,
    parameter int unsigned DW       = DEFAULT_DW,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          ram_rd,
    output logic          ram_wr,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam int unsigned WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [WCW-1:0] WaitLast = WCW'(RD_LAT - 1);

    logic [1:0]     state_q, state_d;
    logic           owner_q, we_q, sel_owner, grant_en;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q, cpu_rdata_q, dma_rdata_q;
    logic [WCW-1:0] wait_q;
    logic           in_issue, in_done, wait_last;

    assign grant_en  = (state_q == IDLE) && (cpu_req || dma_req);
    assign in_issue  = (state_q == ISSUE);
    assign in_done   = (state_q == DONE);
    assign wait_last = (state_q == WAIT) && (wait_q == '0);

    mem_arb_select #(
        .MAX_WAIT (MAX_WAIT)
    ) u_select (
        .clk      (clk),
        .clr      (clr),
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .grant_en (grant_en),
        .owner    (sel_owner)
    );

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cpu_req || dma_req) state_d = ISSUE;
            ISSUE:   state_d = we_q ? DONE : WAIT;
            WAIT:    if (wait_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, grant latches and read-latency counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            owner_q <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                owner_q <= sel_owner;
                we_q    <= (sel_owner == OWN_DMA) ? dma_we    : cpu_we;
                addr_q  <= (sel_owner == OWN_DMA) ? dma_addr  : cpu_addr;
                wdata_q <= (sel_owner == OWN_DMA) ? dma_wdata : cpu_wdata;
            end
            if (in_issue) begin
                wait_q <= WaitLast;
            end else if ((state_q == WAIT) && (wait_q != '0)) begin
                wait_q <= wait_q - WCW'(1);
            end
        end
    end

    // Read data capture at the last WAIT edge; each register only moves on its own reads
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (wait_last) begin
            if (owner_q == OWN_CPU) begin
                cpu_rdata_q <= ram_rdata;
            end else begin
                dma_rdata_q <= ram_rdata;
            end
        end
    end

    // RAM strobes and bus are only driven during ISSUE; acks pulse in DONE
    always_comb begin
        ram_rd    = in_issue && !we_q;
        ram_wr    = in_issue && we_q;
        ram_addr  = in_issue ? addr_q  : '0;
        ram_wdata = in_issue ? wdata_q : '0;
        cpu_ack   = in_done && (owner_q == OWN_CPU);
        dma_ack   = in_done && (owner_q == OWN_DMA);
        // Gated by clr so every output reads 0 while reset is held
        cpu_stall = cpu_req && !cpu_ack && clr;
        busy      = (state_q != IDLE);
    end

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural arbitration/memory model.
module tb_mem_port_arbiter;

    localparam int unsigned RD_LAT   = 1;
    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [8:0]  cpu_addr, dma_addr, ram_addr;
    logic [31:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, ram_wdata, ram_rdata;
    logic        cpu_ack, dma_ack, cpu_stall, ram_rd, ram_wr, busy;

    // second instance with two-cycle RAM latency
    logic        b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
    logic [8:0]  b_cpu_addr, b_dma_addr, b_ram_addr;
    logic [31:0] b_cpu_wdata, b_dma_wdata, b_cpu_rdata, b_dma_rdata, b_ram_wdata, b_ram_rdata;
    logic        b_cpu_ack, b_dma_ack, b_cpu_stall, b_ram_rd, b_ram_wr, b_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(9), .DW(32), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk(clk), .clr(clr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_port_arbiter #(.AW(9), .DW(32), .RD_LAT(2), .MAX_WAIT(MAX_WAIT)) u_dut2 (
        .clk(clk), .clr(clr),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
        .dma_ack(b_dma_ack), .dma_rdata(b_dma_rdata),
        .ram_rd(b_ram_rd), .ram_wr(b_ram_wr), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata), .busy(b_busy)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 5) ? 32'hDEADBEEF : ((32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM models: latency 1 for u_dut, latency 2 for u_dut2
    logic [31:0] ram1 [512];
    logic [31:0] ram2 [512];
    logic [31:0] ram1_q = '0, ram2_s1 = '0, ram2_s2 = '0;
    bit          ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 512; i++) begin
                ram1[i] <= init_val(i);
                ram2[i] <= init_val(i);
            end
            ram_init <= 1'b1;
        end else begin
            if (ram_wr) ram1[ram_addr] <= ram_wdata;
            if (ram_rd) ram1_q <= ram1[ram_addr];
            if (b_ram_wr) ram2[b_ram_addr] <= b_ram_wdata;
            if (b_ram_rd) ram2_s1 <= ram2[b_ram_addr];
            ram2_s2 <= ram2_s1;
        end
    end
    assign ram_rdata   = ram1_q;
    assign b_ram_rdata = ram2_s2;

    // Reference memory and per-requester scoreboards
    typedef struct packed {
        logic        we;
        logic [8:0]  addr;
        logic [31:0] exp;
    } txn_t;
    logic [31:0] ref_mem [512];
    txn_t        q_cpu[$];
    txn_t        q_dma[$];
    bit          sb_en = 1'b1;

    // Monitor state: predicted grant and ack timing from the arbitration rules
    int          n = 0;
    bit          g_pend = 1'b0;
    int          g_n = 0;
    logic        g_we;
    logic [8:0]  g_addr;
    logic [31:0] g_wd;
    int          ack_due [2];
    logic        ack_we [2];
    int          lost = 0;
    logic [31:0] prev_rd [2];
    int          ack_log[$];

    always @(negedge clk) begin
        n++;
        if (!clr) begin
            g_pend = 1'b0;
            lost = 0;
            for (int w = 0; w < 2; w++) begin
                ack_due[w] = -1;
                ack_we[w] = 1'b1;
            end
            prev_rd[0] = cpu_rdata;
            prev_rd[1] = dma_rdata;
        end else begin
            if (ram_rd || ram_wr) check("strobe_excl", 64'(ram_rd && ram_wr), 0);
            if (g_pend && (n == g_n + 1)) begin
                check("issue_rd", ram_rd, !g_we);
                check("issue_wr", ram_wr, g_we);
                check("issue_addr", ram_addr, g_addr);
                check("issue_wdata", ram_wdata, g_wd);
                g_pend = 1'b0;
            end else begin
                if (ram_rd || ram_wr) check("stray_strobe", {ram_rd, ram_wr}, 0);
                check("idle_bus", {ram_addr, ram_wdata}, 0);
            end
            for (int w = 0; w < 2; w++) begin
                logic        a;
                logic [31:0] rd;
                txn_t        t;
                a  = (w == 1) ? dma_ack : cpu_ack;
                rd = (w == 1) ? dma_rdata : cpu_rdata;
                if (ack_due[w] == n) begin
                    check((w == 1) ? "dma_ack_time" : "cpu_ack_time", a, 1);
                    ack_due[w] = -1;
                end else if (a) begin
                    check("unexpected_ack", a, 0);
                end
                if (a) ack_log.push_back(w);
                if (a && sb_en) begin
                    if (((w == 1) ? q_dma.size() : q_cpu.size()) == 0) begin
                        check("sb_empty_on_ack", 1, 0);
                    end else begin
                        t = (w == 1) ? q_dma.pop_front() : q_cpu.pop_front();
                        if (!t.we) check((w == 1) ? "dma_rdata" : "cpu_rdata", rd, t.exp);
                    end
                end
                if (!(a && !ack_we[w])) check("rdata_hold", rd, prev_rd[w]);
                prev_rd[w] = rd;
            end
            if (!busy && (cpu_req || dma_req)) begin
                logic o;
                if (cpu_req && dma_req) begin
                    o = (lost == MAX_WAIT);
                    if (o) lost = 0;
                    else if (lost < MAX_WAIT) lost++;
                end else begin
                    o = dma_req;
                    if (o) lost = 0;
                end
                g_pend = 1'b1;
                g_n    = n;
                g_we   = o ? dma_we : cpu_we;
                g_addr = o ? dma_addr : cpu_addr;
                g_wd   = o ? dma_wdata : cpu_wdata;
                ack_due[o] = n + 2 + (g_we ? 0 : RD_LAT);
                ack_we[o]  = g_we;
            end
        end
    end

    // One transaction under the requester contract; entered and left at posedge+1
    task automatic do_txn(input bit who, input logic we, input logic [8:0] a, input logic [31:0] d);
        txn_t t;
        bit   got;
        t.we = we;
        t.addr = a;
        t.exp = ref_mem[a];
        if (we) ref_mem[a] = d;
        if (who) begin
            q_dma.push_back(t);
            dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
        end else begin
            q_cpu.push_back(t);
            cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = who ? dma_ack : cpu_ack;
        end
        if (!got) check(who ? "dma_ack_timeout" : "cpu_ack_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (who) dma_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    task automatic driver(input bit who);
        for (int i = 0; i < 40; i++) begin
            int unsigned gap;
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            do_txn(who, 1'($urandom_range(0, 1)),
                   who ? 9'(256 + $urandom_range(0, 255)) : 9'($urandom_range(0, 255)),
                   $urandom);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   k, cnt, gl0;
        bit   got;
        txn_t t;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_dma_req = 0; b_dma_we = 0; b_dma_addr = 0; b_dma_wdata = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {cpu_ack, dma_ack, cpu_stall, ram_rd, ram_wr, busy}, 0);
        check("rst_ram_bus", {ram_addr, ram_wdata}, 0);
        check("rst_rdata", {cpu_rdata, dma_rdata}, 0);
        #1 clr = 1'b1;
        @(posedge clk);
        #1;

        // CPU read of preloaded word
        do_txn(0, 0, 9'd5, 0);
        check("t1_rdata", cpu_rdata, 32'hDEADBEEF);

        // DMA write at the top address, then CPU reads it back
        do_txn(1, 1, 9'h1FF, 32'h12345678);
        do_txn(0, 0, 9'h1FF, 0);
        check("t2_rdata", cpu_rdata, 32'h12345678);

        // Request withdrawn and address changed right after the grant
        t.we = 0; t.addr = 9'd3; t.exp = ref_mem[3];
        q_cpu.push_back(t);
        cpu_we = 0; cpu_addr = 9'd3; cpu_req = 1'b1;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_addr = 9'd7;
        @(negedge clk);
        check("t5_ram_addr", ram_addr, 9'd3);
        check("t5_ram_rd", ram_rd, 1);
        cnt = 0;
        repeat (7) begin
            @(negedge clk);
            cnt += int'(cpu_ack);
        end
        check("t5_ack_count", cnt, 1);
        @(posedge clk);
        #1;

        // Both requesters held high: DMA gets every fifth grant
        sb_en = 1'b0;
        gl0 = ack_log.size();
        cpu_we = 0; cpu_addr = 9'd10; dma_we = 0; dma_addr = 9'd300;
        cpu_req = 1'b1; dma_req = 1'b1;
        k = 0;
        while (ack_log.size() < gl0 + 10 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t3_ack_count", 64'(ack_log.size() >= gl0 + 10), 1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0; dma_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ack_log.size() > gl0 + i) begin
                check("t3_grant_order", ack_log[gl0 + i], (i % 5 == 4) ? 1 : 0);
            end
        end
        repeat (6) @(posedge clk);
        #1;

        // Reset during WAIT of a CPU read aborts it
        cpu_we = 0; cpu_addr = 9'd20; cpu_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3 clr = 1'b0;
        #1;
        check("t4_rst_outputs", {cpu_ack, dma_ack, cpu_stall, ram_rd, ram_wr, busy}, 0);
        check("t4_rst_ram_bus", {ram_addr, ram_wdata}, 0);
        check("t4_rst_rdata", {cpu_rdata, dma_rdata}, 0);
        cpu_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 clr = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("t4_no_ack", cpu_ack, 0);
        end
        @(posedge clk);
        #1;
        sb_en = 1'b1;
        do_txn(0, 0, 9'd20, 0);
        check("t4_next_rdata", cpu_rdata, init_val(20));

        // Two-cycle RAM latency instance
        b_cpu_we = 0; b_cpu_addr = 9'd5; b_cpu_req = 1'b1;
        @(posedge clk);
        k = 0; got = 1'b0; cnt = 0;
        while (!got && k < 20) begin
            @(negedge clk);
            k++;
            cnt += int'(b_ram_rd);
            got = b_cpu_ack;
        end
        check("t6_ack_latency", k, 4);
        check("t6_rdata", b_cpu_rdata, 32'hDEADBEEF);
        check("t6_rd_strobes", cnt, 1);
        @(posedge clk);
        #1;
        b_cpu_req = 1'b0;

        // Randomised concurrent traffic in disjoint address halves
        fork
            driver(0);
            driver(1);
        join
        repeat (10) @(posedge clk);
        check("cpu_sb_drain", q_cpu.size(), 0);
        check("dma_sb_drain", q_dma.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
